nmr_bstrm_cmd_loader: RTL and testbench
=======================================

Name: nmr_bstrm_cmd_loader

Overview:
- Upstream stage of the arbitrary-bitstream engine: fills the bitstream command SRAM before the controller/datapath pair is started.
- Accepts 32-bit command words from the host over a valid/ready stream and packs them into 128-bit SRAM lines.
- Writes lines to consecutive SRAM addresses starting at 0, then reports the line count and DONE.
- The controller later reads these lines back through the arbitrated SRAM port.

Parameters:
- WORD_WIDTH, 32, host command word width.
- SRAM_ADDR_WIDTH, 8, SRAM address width.
- SRAM_DAT_WIDTH, 128, SRAM line width; must be an integer multiple of WORD_WIDTH.
- SRAM_BYTEEN_WIDTH, 16, SRAM byte-enable width (SRAM_DAT_WIDTH/8).
- Derived localparam WPL = SRAM_DAT_WIDTH/WORD_WIDTH (default 4).

Ports:
- CLK  in  1  system clock, single clock domain.
- RST  in  1  synchronous, active-high reset.
- START  in  1  one-cycle pulse; begins a load session.
- DIN  in  WORD_WIDTH  host command word.
- DIN_VALID  in  1  DIN holds a valid word.
- DIN_LAST  in  1  qualifies the final word of a session; sampled with DIN_VALID.
- DIN_READY  out  1  loader accepts DIN this cycle.
- SRAM_ADDR  out  SRAM_ADDR_WIDTH  write address.
- SRAM_CS  out  1  chip select.
- SRAM_CLKEN  out  1  clock enable.
- SRAM_WR  out  1  write strobe.
- SRAM_WR_DAT  out  SRAM_DAT_WIDTH  packed line.
- SRAM_BYTEEN  out  SRAM_BYTEEN_WIDTH  byte enables.
- LINES  out  SRAM_ADDR_WIDTH+1  lines written in the current session.
- BUSY  out  1  session in progress.
- DONE  out  1  session completed.
- ERR  out  1  SRAM full before DIN_LAST was seen.

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high.
- Reset values: state IDLE; all outputs 0, including DIN_READY, SRAM_*, LINES, BUSY, DONE and ERR. The line buffer, word index and address register are all cleared.
- States: IDLE, COLLECT, WRITE, DONE_S, ERR_S.
- IDLE, DONE_S, ERR_S:
  - START moves to COLLECT next cycle.
  - Entering COLLECT clears the address, LINES, word index, line buffer, DONE and ERR.
- COLLECT:
  - DIN_READY=1 and BUSY=1.
  - On DIN_VALID&&DIN_READY, DIN is stored in lane word_idx (bits [word_idx*WORD_WIDTH +: WORD_WIDTH]). Word 0 is in the LSBs.
  - If word_idx==WPL-1 or DIN_LAST, go to WRITE and latch last_flag=DIN_LAST.
  - Otherwise word_idx increments.
  - No accept without DIN_VALID; holding DIN_VALID low indefinitely is legal.
- WRITE (exactly one cycle):
  - DIN_READY=0.
  - SRAM_CS=SRAM_CLKEN=SRAM_WR=1, SRAM_ADDR=addr, SRAM_WR_DAT=line buffer, SRAM_BYTEEN all ones.
  - LINES increments the next cycle.
  - Next state:
    - if last_flag, go to DONE_S;
    - else if addr is all-ones, go to ERR_S;
    - else addr+1, word_idx=0, line buffer cleared, back to COLLECT.
- Partial line: unfilled lanes are zero because the buffer is cleared per line. DIN_LAST on lane 0 writes a line with only lane 0 non-zero.
- SRAM signals outside WRITE: CS, CLKEN and WR are 0; BYTEEN is 0; WR_DAT and ADDR hold their last values.
- DONE_S: DONE=1 and BUSY=0, held until START or RST. LINES holds the final count, which spans 1..2^SRAM_ADDR_WIDTH.
- ERR_S: ERR=1, DIN_READY=0 and BUSY=0. LINES equals 2^SRAM_ADDR_WIDTH. Held until START or RST.
- Ignored inputs:
  - START in COLLECT or WRITE is ignored.
  - DIN_LAST without DIN_VALID is ignored.
- A full SRAM with DIN_LAST on the final line is not an error: it goes to DONE_S with LINES=2^SRAM_ADDR_WIDTH.
- Latency: the last accepted word of a line is written 1 cycle after acceptance. DONE rises 2 cycles after the accepted DIN_LAST.
- Throughput: WPL words per WPL+1 cycles.
- RST mid-session: returns to the reset values on the next edge. No SRAM write occurs on that edge or after it, and the partial line is discarded.

Test Plan:
- Reset, START, 8 words 0x1..0x8, last on word 8 -> two writes. Line 0 at addr 0 is 0x00000004_00000003_00000002_00000001 and line 1 at addr 1 is 0x8_7_6_5 (words). LINES=2, DONE=1 two cycles after the last accept, BYTEEN=0xFFFF during writes only.
- 5 words, last on word 5 -> addr 1 line = 0x00000000_00000000_00000000_00000005, LINES=2, DONE=1.
- DIN_VALID toggled 1-0-1 randomly, 4 words -> exactly one write with the correct packing. DIN_READY is low only in the WRITE cycle.
- SRAM_ADDR_WIDTH=2, 17 words with no last -> 4 writes at addr 0..3, then ERR=1, DIN_READY=0, LINES=4. START then clears ERR and restarts at addr 0.
- SRAM_ADDR_WIDTH=2, 16 words with last on word 16 -> DONE=1, ERR=0, LINES=4.
- RST asserted after 2 words of line 0, then a new session of 4 words -> no write before RST. The new line at addr 0 holds only the new words, and START pulses during COLLECT have no effect.

Source files
------------

// File: rtl/nmr_bstrm_cmd_loader.sv
// Packs host command words into SRAM lines and writes them to consecutive
// addresses from 0, reporting the line count and DONE, or ERR on overflow.
module nmr_bstrm_cmd_loader #(
   parameter int WORD_WIDTH        = 32,
   parameter int SRAM_ADDR_WIDTH   = 8,
   parameter int SRAM_DAT_WIDTH    = 128,
   parameter int SRAM_BYTEEN_WIDTH = 16
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         START,
   input  logic [WORD_WIDTH-1:0]        DIN,
   input  logic                         DIN_VALID,
   input  logic                         DIN_LAST,
   output logic                         DIN_READY,
   output logic [SRAM_ADDR_WIDTH-1:0]   SRAM_ADDR,
   output logic                         SRAM_CS,
   output logic                         SRAM_CLKEN,
   output logic                         SRAM_WR,
   output logic [SRAM_DAT_WIDTH-1:0]    SRAM_WR_DAT,
   output logic [SRAM_BYTEEN_WIDTH-1:0] SRAM_BYTEEN,
   output logic [SRAM_ADDR_WIDTH:0]     LINES,
   output logic                         BUSY,
   output logic                         DONE,
   output logic                         ERR
);

   localparam int WPL   = SRAM_DAT_WIDTH / WORD_WIDTH;
   localparam int IDX_W = (WPL > 1) ? $clog2(WPL) : 1;

   localparam logic [IDX_W-1:0]           IDX_LAST  = IDX_W'(WPL - 1);
   localparam logic [IDX_W-1:0]           IDX_ONE   = IDX_W'(1);
   localparam logic [SRAM_ADDR_WIDTH-1:0] ADDR_ONE  = SRAM_ADDR_WIDTH'(1);
   localparam logic [SRAM_ADDR_WIDTH-1:0] ADDR_FULL = {SRAM_ADDR_WIDTH{1'b1}};
   localparam logic [SRAM_ADDR_WIDTH:0]   LINES_ONE = (SRAM_ADDR_WIDTH + 1)'(1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      COLLECT = 3'd1,
      WRITE   = 3'd2,
      DONE_S  = 3'd3,
      ERR_S   = 3'd4
   } state_t;

   state_t                     state_r;
   logic [SRAM_ADDR_WIDTH-1:0] addr_r;
   logic [IDX_W-1:0]           word_idx_r;
   logic [SRAM_DAT_WIDTH-1:0]  line_r;
   logic                       last_flag_r;
   logic [SRAM_DAT_WIDTH-1:0]  line_next_s;

   // Line buffer with the incoming word merged into the current lane.
   always_comb begin
      line_next_s = line_r;
      for (int i = 0; i < WPL; i++) begin
         if (word_idx_r == IDX_W'(i)) begin
            line_next_s[i*WORD_WIDTH +: WORD_WIDTH] = DIN;
         end else begin
            line_next_s[i*WORD_WIDTH +: WORD_WIDTH] = line_r[i*WORD_WIDTH +: WORD_WIDTH];
         end
      end
   end

   // Session FSM; every output is a register updated alongside the state.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r     <= IDLE;
         addr_r      <= '0;
         word_idx_r  <= '0;
         line_r      <= '0;
         last_flag_r <= 1'b0;
         DIN_READY   <= 1'b0;
         SRAM_ADDR   <= '0;
         SRAM_CS     <= 1'b0;
         SRAM_CLKEN  <= 1'b0;
         SRAM_WR     <= 1'b0;
         SRAM_WR_DAT <= '0;
         SRAM_BYTEEN <= '0;
         LINES       <= '0;
         BUSY        <= 1'b0;
         DONE        <= 1'b0;
         ERR         <= 1'b0;
      end else begin
         case (state_r)
            IDLE, DONE_S, ERR_S: begin
               if (START) begin
                  state_r    <= COLLECT;
                  addr_r     <= '0;
                  word_idx_r <= '0;
                  line_r     <= '0;
                  LINES      <= '0;
                  DIN_READY  <= 1'b1;
                  BUSY       <= 1'b1;
                  DONE       <= 1'b0;
                  ERR        <= 1'b0;
               end
            end
            COLLECT: begin
               if (DIN_VALID && DIN_READY) begin
                  line_r <= line_next_s;
                  if ((word_idx_r == IDX_LAST) || DIN_LAST) begin
                     // The merged line goes straight to the SRAM port, so the write lands one cycle after the accept.
                     state_r     <= WRITE;
                     last_flag_r <= DIN_LAST;
                     DIN_READY   <= 1'b0;
                     SRAM_ADDR   <= addr_r;
                     SRAM_CS     <= 1'b1;
                     SRAM_CLKEN  <= 1'b1;
                     SRAM_WR     <= 1'b1;
                     SRAM_WR_DAT <= line_next_s;
                     SRAM_BYTEEN <= {SRAM_BYTEEN_WIDTH{1'b1}};
                  end else begin
                     word_idx_r <= word_idx_r + IDX_ONE;
                  end
               end
            end
            WRITE: begin
               SRAM_CS     <= 1'b0;
               SRAM_CLKEN  <= 1'b0;
               SRAM_WR     <= 1'b0;
               SRAM_BYTEEN <= '0;
               LINES       <= LINES + LINES_ONE;
               if (last_flag_r) begin
                  state_r <= DONE_S;
                  BUSY    <= 1'b0;
                  DONE    <= 1'b1;
               end else if (addr_r == ADDR_FULL) begin
                  state_r <= ERR_S;
                  BUSY    <= 1'b0;
                  ERR     <= 1'b1;
               end else begin
                  state_r    <= COLLECT;
                  addr_r     <= addr_r + ADDR_ONE;
                  word_idx_r <= '0;
                  line_r     <= '0;
                  DIN_READY  <= 1'b1;
               end
            end
            default: begin
               state_r    <= IDLE;
               DIN_READY  <= 1'b0;
               SRAM_CS    <= 1'b0;
               SRAM_CLKEN <= 1'b0;
               SRAM_WR    <= 1'b0;
               BUSY       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nmr_bstrm_cmd_loader.sv
// Directed bench for nmr_bstrm_cmd_loader: a default instance and a
// 4-line (SRAM_ADDR_WIDTH=2) instance share one stimulus stream.
module tb_nmr_bstrm_cmd_loader;

   logic         clk;
   logic         rst;
   logic         start;
   logic [31:0]  din;
   logic         din_valid;
   logic         din_last;

   logic         rdy_a, cs_a, clken_a, wr_a, busy_a, done_a, err_a;
   logic [7:0]   addr_a;
   logic [127:0] dat_a;
   logic [15:0]  be_a;
   logic [8:0]   lines_a;

   logic         rdy_b, cs_b, clken_b, wr_b, busy_b, done_b, err_b;
   logic [1:0]   addr_b;
   logic [127:0] dat_b;
   logic [15:0]  be_b;
   logic [2:0]   lines_b;

   int checks = 0;
   int errors = 0;
   int be_bad_a = 0;
   bit sel_b = 1'b0;

   logic [7:0]   q_addr_a[$];
   logic [127:0] q_dat_a[$];
   logic [1:0]   q_addr_b[$];
   logic [127:0] q_dat_b[$];

   nmr_bstrm_cmd_loader dut_a (
      .CLK(clk), .RST(rst), .START(start), .DIN(din), .DIN_VALID(din_valid),
      .DIN_LAST(din_last), .DIN_READY(rdy_a), .SRAM_ADDR(addr_a), .SRAM_CS(cs_a),
      .SRAM_CLKEN(clken_a), .SRAM_WR(wr_a), .SRAM_WR_DAT(dat_a), .SRAM_BYTEEN(be_a),
      .LINES(lines_a), .BUSY(busy_a), .DONE(done_a), .ERR(err_a)
   );

   nmr_bstrm_cmd_loader #(.SRAM_ADDR_WIDTH(2)) dut_b (
      .CLK(clk), .RST(rst), .START(start), .DIN(din), .DIN_VALID(din_valid),
      .DIN_LAST(din_last), .DIN_READY(rdy_b), .SRAM_ADDR(addr_b), .SRAM_CS(cs_b),
      .SRAM_CLKEN(clken_b), .SRAM_WR(wr_b), .SRAM_WR_DAT(dat_b), .SRAM_BYTEEN(be_b),
      .LINES(lines_b), .BUSY(busy_b), .DONE(done_b), .ERR(err_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write monitor: records every SRAM write and flags byte enables outside writes.
   always @(negedge clk) begin
      if (wr_a && cs_a && clken_a) begin
         q_addr_a.push_back(addr_a);
         q_dat_a.push_back(dat_a);
         if (be_a !== 16'hFFFF) be_bad_a = be_bad_a + 1;
      end else if (be_a !== 16'h0000) begin
         be_bad_a = be_bad_a + 1;
      end
      if (wr_b && cs_b && clken_b) begin
         q_addr_b.push_back(addr_b);
         q_dat_b.push_back(dat_b);
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] d, input logic last);
      int   n;
      logic rdy;
      din       = d;
      din_valid = 1'b1;
      din_last  = last;
      n = 0;
      do begin
         @(negedge clk);
         rdy = sel_b ? rdy_b : rdy_a;
         @(posedge clk);
         n++;
      end while (!rdy && n < 20);
      #1;
      din_valid = 1'b0;
      din_last  = 1'b0;
      if (!rdy) chk("send_timeout", {127'd0, rdy}, 128'd1);
   endtask

   function automatic logic [127:0] line4(input int w0, input int w1, input int w2, input int w3);
      return {32'(w3), 32'(w2), 32'(w1), 32'(w0)};
   endfunction

   initial begin
      rst = 1'b1; start = 1'b0; din = 32'd0; din_valid = 1'b0; din_last = 1'b0;
      cyc(); cyc();

      // Reset values
      chk("rst_ready", {127'd0, rdy_a}, 128'd0);
      chk("rst_flags", {124'd0, busy_a, done_a, err_a, wr_a}, 128'd0);
      chk("rst_lines", {119'd0, lines_a}, 128'd0);
      chk("rst_sram", {104'd0, addr_a, be_a}, 128'd0);
      chk("rst_dat", dat_a, 128'd0);
      rst = 1'b0;
      cyc();

      // Two full lines, last on word 8
      pulse_start();
      chk("t1_ready", {127'd0, rdy_a}, 128'd1);
      for (int i = 1; i <= 8; i++) send_word(32'(i), (i == 8));
      @(negedge clk);
      chk("t1_wr_cycle", {125'd0, wr_a, rdy_a, done_a}, 128'd4);
      chk("t1_be_wr", {112'd0, be_a}, 128'h0000_FFFF);
      cyc();
      chk("t1_done", {125'd0, done_a, busy_a, err_a}, 128'd4);
      chk("t1_lines", {119'd0, lines_a}, 128'd2);
      chk("t1_nwrites", 128'(q_dat_a.size()), 128'd2);
      chk("t1_addr0", {120'd0, q_addr_a[0]}, 128'd0);
      chk("t1_line0", q_dat_a[0], 128'h00000004_00000003_00000002_00000001);
      chk("t1_addr1", {120'd0, q_addr_a[1]}, 128'd1);
      chk("t1_line1", q_dat_a[1], 128'h00000008_00000007_00000006_00000005);
      chk("t1_hold_dat", dat_a, 128'h00000008_00000007_00000006_00000005);
      chk("t1_be_idle", 128'(be_bad_a), 128'd0);
      q_addr_a.delete(); q_dat_a.delete();

      // Partial second line, last on word 5
      pulse_start();
      chk("t2_restart", {119'd0, lines_a}, 128'd0);
      chk("t2_done_clr", {127'd0, done_a}, 128'd0);
      for (int i = 1; i <= 5; i++) send_word(32'(i), (i == 5));
      cyc();
      chk("t2_done", {126'd0, done_a, err_a}, 128'd2);
      chk("t2_lines", {119'd0, lines_a}, 128'd2);
      chk("t2_nwrites", 128'(q_dat_a.size()), 128'd2);
      chk("t2_addr1", {120'd0, q_addr_a[1]}, 128'd1);
      chk("t2_line1", q_dat_a[1], 128'h00000000_00000000_00000000_00000005);
      q_addr_a.delete(); q_dat_a.delete();

      // Gapped valid, one full line, no last
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
            chk("t3_ready_gap", {127'd0, rdy_a}, 128'd1);
            cyc();
         end
         send_word(32'h000000A0 + 32'(i), 1'b0);
      end
      chk("t3_wr_ready", {126'd0, wr_a, rdy_a}, 128'd2);
      cyc();
      chk("t3_back", {124'd0, rdy_a, wr_a, busy_a, done_a}, 128'd10);
      chk("t3_lines", {119'd0, lines_a}, 128'd1);
      chk("t3_nwrites", 128'(q_dat_a.size()), 128'd1);
      chk("t3_line0", q_dat_a[0], 128'h000000A3_000000A2_000000A1_000000A0);

      // Small SRAM overflow: 16 words with no last fill all 4 lines
      pulse_rst();
      sel_b = 1'b1;
      q_addr_b.delete(); q_dat_b.delete();
      pulse_start();
      for (int i = 1; i <= 16; i++) send_word(32'(i), 1'b0);
      cyc();
      chk("t4_err", {124'd0, err_b, done_b, busy_b, rdy_b}, 128'd8);
      chk("t4_lines", {125'd0, lines_b}, 128'd4);
      chk("t4_nwrites", 128'(q_dat_b.size()), 128'd4);
      for (int j = 0; j < 4; j++) begin
         if (j < q_dat_b.size()) begin
            chk("t4_addr", {126'd0, q_addr_b[j]}, 128'(j));
            chk("t4_line", q_dat_b[j], line4(4*j+1, 4*j+2, 4*j+3, 4*j+4));
         end
      end
      din = 32'h00000011; din_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("t4_no_accept", {126'd0, rdy_b, err_b}, 128'd1);
      end
      din_valid = 1'b0;
      chk("t4_no_write", 128'(q_dat_b.size()), 128'd4);
      pulse_start();
      chk("t4_restart", {126'd0, err_b, rdy_b}, 128'd1);
      chk("t4_restart_lines", {125'd0, lines_b}, 128'd0);
      q_addr_b.delete(); q_dat_b.delete();
      send_word(32'h00000055, 1'b1);
      cyc();
      chk("t4_re_done", {127'd0, done_b}, 128'd1);
      chk("t4_re_addr", {126'd0, q_addr_b[0]}, 128'd0);
      chk("t4_re_line", q_dat_b[0], 128'h00000000_00000000_00000000_00000055);

      // Small SRAM exactly full with last on final word
      pulse_start();
      q_addr_b.delete(); q_dat_b.delete();
      for (int i = 1; i <= 16; i++) send_word(32'(i), (i == 16));
      cyc();
      chk("t5_done_err", {126'd0, done_b, err_b}, 128'd2);
      chk("t5_lines", {125'd0, lines_b}, 128'd4);
      chk("t5_nwrites", 128'(q_dat_b.size()), 128'd4);
      chk("t5_line3", q_dat_b[3], 128'h00000010_0000000F_0000000E_0000000D);

      // Reset mid-line, then ignored START pulses during COLLECT
      sel_b = 1'b0;
      pulse_rst();
      pulse_start();
      q_addr_a.delete(); q_dat_a.delete();
      send_word(32'h00000011, 1'b0);
      send_word(32'h00000022, 1'b0);
      pulse_rst();
      cyc();
      chk("t6_no_write", 128'(q_dat_a.size()), 128'd0);
      chk("t6_rst_state", {125'd0, rdy_a, busy_a, wr_a}, 128'd0);
      pulse_start();
      send_word(32'h00000031, 1'b0);
      pulse_start();
      send_word(32'h00000032, 1'b0);
      send_word(32'h00000033, 1'b0);
      pulse_start();
      send_word(32'h00000034, 1'b0);
      cyc();
      chk("t6_nwrites", 128'(q_dat_a.size()), 128'd1);
      chk("t6_addr0", {120'd0, q_addr_a[0]}, 128'd0);
      chk("t6_line0", q_dat_a[0], 128'h00000034_00000033_00000032_00000031);
      chk("t6_lines", {119'd0, lines_a}, 128'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
